// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an internal transmit FIFO.
// Frames are start, DATA_BITS payload bits (LSB first), optional parity, stop.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   send_data  - character to queue
//   send_ce    - write strobe, accepted when send_full is low
//   send_full  - FIFO full, writes are dropped
//   send_busy  - frame in progress or characters queued
//   fifo_count - queued characters, excluding the one on the line
//   Tx         - registered serial output, idle high
module uart_tx_param #(
  parameter int CLOCK      = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          send_data,
  input  logic                          send_ce,
  output logic                          send_full,
  output logic                          send_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          Tx
);

  localparam int CPB = CLOCK / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
  // Any mode other than odd or even sends no parity bit.
  localparam bit            HAS_PAR   = (PARITY == 1) || (PARITY == 2);
  localparam bit            ODD_PAR   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 full, empty, push, pop, last;
  logic [DATA_BITS-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // Uses the registered full flag, so a pop on the same edge
  // does not make room for a write.
  assign push  = send_ce & ~full;
  assign head  = mem_q[rd_ptr_q];
  assign last  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = ODD_PAR ? ~^head : ^head;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          tx_d    = sh_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      S_PARITY: begin
        if (last) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (last) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 1'b1;
          end else if (!empty) begin
            // Chain straight into the next start bit.
            pop     = 1'b1;
            sh_d    = head;
            par_d   = ODD_PAR ? ~^head : ^head;
            tx_d    = 1'b0;
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= send_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign send_full  = full;
  assign send_busy  = (state_q != S_IDLE) | ~empty;
  assign fifo_count = count_q;
  assign Tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param.
// Four instances: 8N1, 8E1, 8O1, 7N2, all at 16 clocks per bit.
module tb_uart_tx_param;

  localparam int CPB = 16;

  typedef struct {
    int data;
    int par;
  } exp_t;

  typedef struct {
    int d;
    int data;
    int par;
    int len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ce;
  logic [8:0] dat [4];
  logic [3:0] tx_w;
  logic [3:0] busy;
  logic [3:0] full;
  logic [2:0] cnt [4];

  int   total = 0;
  int   bad   = 0;
  int   frames [4];
  int   gaps0 [$];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  exp_t q3 [$];

  int dbits [4] = '{8, 8, 8, 7};
  int pmode [4] = '{0, 2, 1, 0};
  int sbits [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_param #(
    .CLOCK(16), .BAUD(1), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst(rst),
    .send_data(dat[0][7:0]), .send_ce(ce[0]),
    .send_full(full[0]), .send_busy(busy[0]),
    .fifo_count(cnt[0]), .Tx(tx_w[0])
  );

  uart_tx_param #(
    .CLOCK(16), .BAUD(1), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst),
    .send_data(dat[1][7:0]), .send_ce(ce[1]),
    .send_full(full[1]), .send_busy(busy[1]),
    .fifo_count(cnt[1]), .Tx(tx_w[1])
  );

  uart_tx_param #(
    .CLOCK(16), .BAUD(1), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .rst(rst),
    .send_data(dat[2][7:0]), .send_ce(ce[2]),
    .send_full(full[2]), .send_busy(busy[2]),
    .fifo_count(cnt[2]), .Tx(tx_w[2])
  );

  uart_tx_param #(
    .CLOCK(16), .BAUD(1), .DATA_BITS(7),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u3 (
    .clk(clk), .rst(rst),
    .send_data(dat[3][6:0]), .send_ce(ce[3]),
    .send_full(full[3]), .send_busy(busy[3]),
    .fifo_count(cnt[3]), .Tx(tx_w[3])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int data, input int par);
    exp_t e;
    e.data = data;
    e.par  = par;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic get_exp(input int d, output bit ok, output exp_t e);
    ok     = 1'b0;
    e.data = 0;
    e.par  = 0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default:
         if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Line monitor: on each start bit pops the next expected character
  // and checks Tx on every cycle of the frame.
  task automatic monitor(input int d);
    int          gap;
    int          nb;
    int          errs;
    bit          ok;
    bit          abort;
    exp_t        e;
    logic [15:0] bits;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx_w[d] !== 1'b0) begin
        gap++;
        continue;
      end
      get_exp(d, ok, e);
      chk($sformatf("frame_expected_d%0d", d), 32'(ok), 32'd1);
      if (!ok) begin
        while (tx_w[d] === 1'b0) @(negedge clk);
        gap = 0;
        continue;
      end
      bits    = '1;
      bits[0] = 1'b0;
      nb      = 1;
      for (int i = 0; i < dbits[d]; i++) begin
        bits[nb] = e.data[i];
        nb++;
      end
      if (pmode[d] != 0) begin
        bits[nb] = e.par[0];
        nb++;
      end
      nb    = nb + sbits[d];
      errs  = 0;
      abort = 1'b0;
      for (int c = 0; c < nb * CPB && !abort; c++) begin
        if (c > 0) begin
          @(negedge clk);
          if (rst !== 1'b0) abort = 1'b1;
        end
        if (!abort && tx_w[d] !== bits[c / CPB]) errs++;
      end
      if (!abort) begin
        chk($sformatf("frame_d%0d_%0h", d, e.data), 32'(errs), 32'd0);
        frames[d]++;
        if (d == 0) gaps0.push_back(gap);
      end
      gap = 0;
    end
  endtask

  task automatic send_timed(input int d, input int data,
                            input int par, input int len);
    int n;
    push_exp(d, data, par);
    @(posedge clk); #1;
    ce[d]  = 1'b1;
    dat[d] = 9'(data);
    @(posedge clk); #1;
    ce[d]  = 1'b0;
    @(negedge clk);
    chk($sformatf("tx_idle_at_E0_d%0d", d), 32'(tx_w[d]), 32'd1);
    chk($sformatf("count_at_E0_d%0d", d), 32'(cnt[d]), 32'd1);
    @(negedge clk);
    chk($sformatf("tx_start_at_E1_d%0d", d), 32'(tx_w[d]), 32'd0);
    chk($sformatf("count_at_E1_d%0d", d), 32'(cnt[d]), 32'd0);
    n = 2;
    while (busy[d] === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("frame_cycles_d%0d_%0h", d, data), 32'(n - 2), 32'(len));
  endtask

  task automatic wait_frames(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (frames[d] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("frames_done_d%0d", d), 32'(frames[d]), 32'(target));
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    while (busy[d] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_d%0d", d), 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [9];
    int   ec [6];
    int   ef [6];
    int   et [6];
    int   f0;
    int   n;
    int   lows;

    vt[0] = '{0, 'hA5, 0, 160};
    vt[1] = '{0, 'h00, 0, 160};
    vt[2] = '{0, 'hFF, 0, 160};
    vt[3] = '{1, 'hA5, 0, 176};
    vt[4] = '{1, 'h01, 1, 176};
    vt[5] = '{2, 'hA5, 1, 176};
    vt[6] = '{2, 'h07, 0, 176};
    vt[7] = '{3, 'h41, 0, 160};
    vt[8] = '{3, 'h7F, 0, 160};
    ec    = '{1, 1, 2, 3, 4, 4};
    ef    = '{0, 0, 0, 0, 1, 1};
    et    = '{1, 0, 0, 0, 0, 0};

    ce = '0;
    for (int i = 0; i < 4; i++) begin
      dat[i]    = '0;
      frames[i] = 0;
    end

    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_tx_d%0d", d), 32'(tx_w[d]), 32'd1);
      chk($sformatf("rst_busy_d%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_full_d%0d", d), 32'(full[d]), 32'd0);
      chk($sformatf("rst_count_d%0d", d), 32'(cnt[d]), 32'd0);
    end

    for (int v = 0; v < 9; v++) begin
      send_timed(vt[v].d, vt[v].data, vt[v].par, vt[v].len);
    end

    // Six back-to-back writes into an idle 4-deep FIFO.
    f0 = frames[0];
    gaps0.delete();
    for (int i = 1; i <= 5; i++) push_exp(0, i, 0);
    @(posedge clk); #1;
    ce[0]  = 1'b1;
    dat[0] = 9'd1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 5) dat[0] = 9'(k + 2);
      else       ce[0]  = 1'b0;
      @(negedge clk);
      chk($sformatf("burst_count_%0d", k), 32'(cnt[0]), 32'(ec[k]));
      chk($sformatf("burst_full_%0d", k), 32'(full[0]), 32'(ef[k]));
      chk($sformatf("burst_tx_%0d", k), 32'(tx_w[0]), 32'(et[k]));
    end
    wait_frames(0, f0 + 5, 5 * 160 + 200);
    chk("burst_gap_records", 32'(gaps0.size()), 32'd5);
    for (int i = 1; i < 5 && i < gaps0.size(); i++) begin
      chk($sformatf("burst_gap_%0d", i), 32'(gaps0[i]), 32'd0);
    end
    wait_idle(0, 400);
    chk("burst_queue_drained", 32'(q0.size()), 32'd0);

    // Write held while full across a pop, then push+pop at count 2.
    f0 = frames[0];
    for (int i = 'h11; i <= 'h15; i++) push_exp(0, i, 0);
    @(posedge clk); #1;
    ce[0]  = 1'b1;
    dat[0] = 9'h11;
    for (int i = 'h12; i <= 'h15; i++) begin
      @(posedge clk); #1;
      dat[0] = 9'(i);
    end
    @(posedge clk); #1;
    dat[0] = 9'h16;
    @(negedge clk);
    chk("fill_count", 32'(cnt[0]), 32'd4);
    chk("fill_full", 32'(full[0]), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cnt[0] == 3'd4 && n < 400);
    ce[0] = 1'b0;
    chk("full_write_with_pop", 32'(cnt[0]), 32'd3);
    repeat (319) @(negedge clk);
    chk("count_before_same_edge", 32'(cnt[0]), 32'd2);
    push_exp(0, 'h17, 0);
    ce[0]  = 1'b1;
    dat[0] = 9'h17;
    @(negedge clk);
    ce[0]  = 1'b0;
    chk("push_pop_same_edge", 32'(cnt[0]), 32'd2);
    wait_frames(0, f0 + 6, 6 * 160 + 200);
    wait_idle(0, 400);
    chk("pushpop_queue_drained", 32'(q0.size()), 32'd0);

    // Reset in the middle of a data bit with two characters queued.
    push_exp(0, 'h21, 0);
    @(posedge clk); #1;
    ce[0]  = 1'b1;
    dat[0] = 9'h21;
    @(posedge clk); #1;
    dat[0] = 9'h22;
    @(posedge clk); #1;
    dat[0] = 9'h23;
    @(posedge clk); #1;
    ce[0]  = 1'b0;
    @(negedge clk);
    chk("prereset_count", 32'(cnt[0]), 32'd2);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midframe_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("midframe_rst_count", 32'(cnt[0]), 32'd0);
    chk("midframe_rst_busy", 32'(busy[0]), 32'd0);
    chk("midframe_rst_full", 32'(full[0]), 32'd0);
    q0.delete();
    f0   = frames[0];
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
    end
    chk("post_rst_line_quiet", 32'(lows), 32'd0);
    chk("post_rst_no_frames", 32'(frames[0]), 32'(f0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
